// File: rtl/pp_writeback.sv
// Post-process writeback: buffers packed int8 vectors in a small FIFO and streams them as 32-bit words to SRAM.
// Optional stall performance counter is built when PP_WRITEBACK_PERF_EN is defined.
module pp_writeback #(
    parameter int LANES = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [LANES*8-1:0]   in_data,
    input  logic                 cfg_start,
    input  logic [AW-1:0]        cfg_base,
    input  logic [15:0]          cfg_num_vec,
    output logic                 mem_req,
    output logic [AW-1:0]        mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic                 mem_gnt,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [31:0]          stall_cnt
);

    localparam int WPV = LANES / 4;
    localparam int VW  = LANES * 8;
    localparam int WCW = (WPV > 1) ? $clog2(WPV) : 1;
    localparam int PW  = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } state_e;

    function automatic logic [31:0] word_of(input logic [VW-1:0] v, input logic [WCW-1:0] k);
        return v[int'(k)*32 +: 32];
    endfunction

    state_e          state_q, state_d;
    logic [15:0]     num_vec_q, num_vec_d;
    logic [15:0]     vec_cnt_q, vec_cnt_d;
    logic [WCW-1:0]  word_cnt_q, word_cnt_d;
    logic [VW-1:0]   vec_q, vec_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;
    logic            mem_req_q, mem_req_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            overflow_q, overflow_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [VW-1:0]   fifo_mem [DEPTH];
    logic            empty_s, full_s, push_s, pop_s, start_s;
    logic [VW-1:0]   head_s;

    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    assign head_s  = fifo_mem[rd_ptr_q[PW-2:0]];
    assign start_s = (state_q == IDLE) && cfg_start;

    // Next-state, datapath and FIFO-pointer logic
    always_comb begin
        state_d     = state_q;
        num_vec_d   = num_vec_q;
        vec_cnt_d   = vec_cnt_q;
        word_cnt_d  = word_cnt_q;
        vec_d       = vec_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        overflow_d  = overflow_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pop_s       = 1'b0;
        push_s      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    num_vec_d  = cfg_num_vec;
                    mem_addr_d = cfg_base;
                    vec_cnt_d  = 16'd0;
                    word_cnt_d = '0;
                    state_d    = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                if (vec_cnt_q == num_vec_q) begin
                    state_d = FINISH;
                end else if (!empty_s) begin
                    pop_s       = 1'b1;
                    vec_d       = head_s;
                    word_cnt_d  = '0;
                    mem_wdata_d = head_s[31:0];
                    state_d     = WRITE;
                end else begin
                    state_d = FETCH;
                end
            end
            WRITE: begin
                if (mem_gnt) begin
                    mem_addr_d = mem_addr_q + AW'(1);
                    if (word_cnt_q == WCW'(WPV - 1)) begin
                        vec_cnt_d = vec_cnt_q + 16'd1;
                        state_d   = FETCH;
                    end else begin
                        word_cnt_d  = word_cnt_q + WCW'(1);
                        mem_wdata_d = word_of(vec_q, word_cnt_q + WCW'(1));
                    end
                end else begin
                    state_d = WRITE;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A full FIFO still accepts when the head leaves in the same cycle
        push_s = in_valid && busy_q && (!full_s || pop_s);

        if (start_s) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
            rd_ptr_d = pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        end

        // A dropped vector must stay visible even if a start clears the flag in the same cycle
        if (in_valid && !push_s) begin
            overflow_d = 1'b1;
        end else if (start_s) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        mem_req_d = (state_d == WRITE);
        done_d    = (state_d == FINISH);
        busy_d    = (state_d != IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            num_vec_q   <= 16'd0;
            vec_cnt_q   <= 16'd0;
            word_cnt_q  <= '0;
            vec_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            mem_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            num_vec_q   <= num_vec_d;
            vec_cnt_q   <= vec_cnt_d;
            word_cnt_q  <= word_cnt_d;
            vec_q       <= vec_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_req_q   <= mem_req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Vector storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem[wr_ptr_q[PW-2:0]] <= in_data;
        end
    end

`ifdef PP_WRITEBACK_PERF_EN
    logic [31:0] stall_q;

    // Saturating count of cycles where a write waits for grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 32'd0;
        end else if (start_s) begin
            stall_q <= 32'd0;
        end else if (mem_req_q && !mem_gnt && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'd0;
`endif

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/pp_writeback.md
Name: pp_writeback

Overview:
- Downstream neighbour of the 32-lane post-process array.
- Captures each packed int8 result vector on the array's one-cycle done pulse and buffers it in a small vector FIFO.
- Serialises each vector into 32-bit words and writes them to output feature-map SRAM through a req/gnt port, with linear address generation from a programmed base.
- The upstream array has no backpressure, so the FIFO absorbs memory stalls; loss of data is flagged, never hidden.

Parameters:
- LANES, 32, int8 lanes per input vector; must be a multiple of 4.
- DEPTH, 4, vector FIFO depth; power of 2, at least 2.
- AW, 16, memory word-address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  one-cycle pulse, driven by the post-process array's done.
- in_data  in  LANES*8  packed result; [i*8+:8] = lane i.
- cfg_start  in  1  pulse; arms a job. Ignored while busy.
- cfg_base  in  AW  first word address, latched on cfg_start.
- cfg_num_vec  in  16  vectors in the job, latched on cfg_start.
- mem_req  out  1  write request.
- mem_addr  out  AW  word address.
- mem_wdata  out  32  write data.
- mem_gnt  in  1  write accepted this cycle when mem_req=1.
- busy  out  1  job active.
- done  out  1  one-cycle pulse at job end.
- overflow  out  1  sticky error flag; cleared only by cfg_start or reset.
- stall_cnt  out  32  performance counter (optional feature).

Behaviour:
- Reset: every output is 0, the FIFO is empty, and the FSM is in IDLE. Reset is asynchronous, so mem_req drops immediately on reset assertion, including mid-job.
- Constant: WPV = LANES/4 words per vector (8 at default).
- Word packing: word k carries lanes 4k..4k+3, with lane 4k in bits [7:0] and lane 4k+3 in bits [31:24].
- Addressing: vector v, word k is written to cfg_base + v*WPV + k. The address wraps modulo 2^AW with no flag.
- Capture rule:
  - in_valid with busy=1 and the FIFO not full pushes in_data.
  - When the FIFO is full, a push is still accepted if a pop occurs in the same cycle.
  - When the FIFO is full and there is no pop, the vector is dropped and overflow is set.
  - in_valid with busy=0 drops the vector and sets overflow.
- FSM states: IDLE, FETCH, WRITE, FINISH.
  - IDLE: on cfg_start, latch cfg_base and cfg_num_vec, clear the vector and word counters, clear overflow, set busy=1, go to FETCH.
  - FETCH:
    - If vec_cnt == num_vec, go to FINISH.
    - Else if the FIFO is not empty, pop the head into vec_r, set word_cnt=0, go to WRITE.
    - Else stay in FETCH.
  - WRITE:
    - mem_req=1. mem_addr and mem_wdata are registered and stay stable until mem_gnt=1.
    - On gnt, advance word_cnt and address; the next word is presented the following cycle, so with gnt tied high there is one word per cycle.
    - On gnt of word WPV-1, increment vec_cnt and go to FETCH.
  - FINISH: done=1 for one cycle, busy=0 on the next cycle, go to IDLE.
- Latency: with the FIFO empty, the FSM in FETCH and gnt tied high:
  - in_valid at cycle t pushes into the FIFO at t.
  - The pop happens at t+1.
  - The first mem_req appears at t+2.
  - The last word is granted at t+1+WPV.
- cfg_num_vec=0: busy is 1 for the FETCH and FINISH cycles, done pulses 2 cycles after cfg_start, and no memory requests are issued.
- Vectors left in the FIFO after FINISH are discarded on the next cfg_start.
- cfg_start while busy has no effect on any state.

Optional Feature:
- Macro PP_WRITEBACK_PERF_EN.
- Defined: stall_cnt increments every cycle with mem_req=1 and mem_gnt=0, saturates at 0xFFFFFFFF, and is cleared on cfg_start. Its value holds after done.
- Undefined: stall_cnt is tied to 0 and no counter logic is built.

Test Plan:
- Single vector, 1 vector at base 0x0100, lane i = i, gnt tied high:
  - Required response: 8 writes to 0x0100..0x0107, with word 0 = 0x03020100 and word 7 = 0x1F1E1D1C.
  - done pulses once; overflow=0.
- Random gnt (50%), job of 3 vectors:
  - Required response: address and data stay stable while gnt=0, and all 24 words are in order at 0x0100..0x0117.
  - With PP_WRITEBACK_PERF_EN defined, stall_cnt equals the count of req & !gnt cycles.
- Overflow, DEPTH=4, gnt held low, 6 back-to-back in_valid pulses:
  - Required response: the first vector moves into vec_r and 4 are buffered, so the 6th vector is dropped and overflow=1.
  - After gnt is released, 5 vectors are written.
- Full-with-pop, FIFO full:
  - Stimulus: in_valid arrives in the same cycle the FSM pops.
  - Required response: the vector is accepted, overflow stays 0, and the data order is preserved.
- Edge cases:
  - cfg_num_vec=0 → done pulses 2 cycles after start, with no mem_req.
  - in_valid while idle → overflow=1.
  - cfg_start while busy → ignored; base and count are unchanged.
- Reset mid-WRITE:
  - Stimulus: rst_n asserted in the middle of a job.
  - Required response: mem_req drops immediately and all outputs go to 0.
  - A new job after reset writes from its own base with correct data.
